vend_input_conditioner: RTL

- Front-end stage sitting directly upstream of the vending controller.
- Synchronises and debounces the raw coin-sensor and two selection-button inputs.
- Qualifies coin pulse width to reject short glitches and detect jams.
- Emits clean single-cycle quarter_in, select1 and select2 pulses; the controller consumes these directly.

---
 rtl/vend_input_conditioner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vend_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : vend_input_conditioner
// Description : Front end for the vending controller. Synchronises and
//               debounces the coin sensor and two selection buttons, qualifies
//               coin pulse width (short-coin reject, jam detect) and emits
//               clean single-cycle quarter_in / select1 / select2 pulses.
//               Optional feature macro: VEND_COIN_COUNT_EN adds saturating
//               coin_count[15:0] and jam_count[7:0] outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int COIN_MIN    = 3,
    parameter int COIN_MAX    = 20,
    parameter int WID_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coin_raw,
    input  logic        sel1_raw,
    input  logic        sel2_raw,
    input  logic        accept_en,
    output logic        quarter_in,
    output logic        select1,
    output logic        select2,
    output logic        coin_reject,
`ifdef VEND_COIN_COUNT_EN
    output logic        coin_jam,
    output logic [15:0] coin_count,
    output logic [7:0]  jam_count
`else
    output logic        coin_jam
`endif
);

    // Channel 0 = coin, 1 = button 1, 2 = button 2.
    localparam int c_NCH = 3;
    // The debounce counter never holds more than DEB_CYCLES-1.
    localparam int c_DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MEAS = 2'd1;
    localparam logic [1:0] c_ST_JAM  = 2'd2;

    localparam logic [WID_W-1:0] c_WID_ONE = WID_W'(1);
    localparam logic [WID_W-1:0] c_WID_MIN = WID_W'(COIN_MIN);
    localparam logic [WID_W-1:0] c_WID_MAX = WID_W'(COIN_MAX);
    localparam logic [WID_W-1:0] c_WID_SAT = WID_W'(COIN_MAX + 1);

    logic [c_NCH-1:0] w_raw;
    logic [c_NCH-1:0] w_db;
    logic             w_coin_db;

    assign w_raw     = {sel2_raw, sel1_raw, coin_raw};
    assign w_coin_db = w_db[0];

    genvar gi;
    generate
        for (gi = 0; gi < c_NCH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_DEB_W-1:0]     r_cnt;
            logic                   r_db;

            // Metastability synchroniser: shift the raw level through SYNC_STAGES flops.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                end
            end

            // Debouncer: toggle the level after DEB_CYCLES consecutive differing samples.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync[SYNC_STAGES-1] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DEB_W'(1);
                end
            end

            assign w_db[gi] = r_db;
        end
    endgenerate

    logic [1:0] r_sel_db_q;

    // Registered rising-edge detect of both debounced buttons; release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_db_q <= 2'b00;
            select1    <= 1'b0;
            select2    <= 1'b0;
        end else begin
            r_sel_db_q <= w_db[2:1];
            select1    <= w_db[1] & ~r_sel_db_q[0];
            select2    <= w_db[2] & ~r_sel_db_q[1];
        end
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WID_W-1:0] r_wid;
    logic [WID_W-1:0] w_wid_nxt;
    logic             w_quarter_nxt;
    logic             w_reject_nxt;
    logic             w_jam_entry;

    // Coin qualification: measure debounced-high width, decide on the falling cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_wid_nxt     = r_wid;
        w_quarter_nxt = 1'b0;
        w_reject_nxt  = 1'b0;
        w_jam_entry   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_coin_db) begin
                    w_state_nxt = c_ST_MEAS;
                    w_wid_nxt   = c_WID_ONE;
                end
            end
            c_ST_MEAS: begin
                if (w_coin_db) begin
                    // One more high cycle past COIN_MAX means the coin is stuck.
                    if (r_wid >= c_WID_MAX) begin
                        w_state_nxt = c_ST_JAM;
                        w_wid_nxt   = c_WID_SAT;
                        w_jam_entry = 1'b1;
                    end else begin
                        w_wid_nxt = r_wid + c_WID_ONE;
                    end
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    if ((r_wid >= c_WID_MIN) && accept_en) begin
                        w_quarter_nxt = 1'b1;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            c_ST_JAM: begin
                w_wid_nxt = c_WID_SAT;
                if (!w_coin_db) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_wid_nxt   = '0;
            end
        endcase
    end

    // Coin FSM state, width counter and registered result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_wid       <= '0;
            quarter_in  <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wid       <= w_wid_nxt;
            quarter_in  <= w_quarter_nxt;
            coin_reject <= w_reject_nxt;
        end
    end

    assign coin_jam = (r_state == c_ST_JAM);

`ifdef VEND_COIN_COUNT_EN
    logic [15:0] r_coin_count;
    logic [7:0]  r_jam_count;

    // Saturating event counters; coin_count moves on the same edge as quarter_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_count <= 16'd0;
            r_jam_count  <= 8'd0;
        end else begin
            if (w_quarter_nxt && (r_coin_count != 16'hFFFF)) begin
                r_coin_count <= r_coin_count + 16'd1;
            end
            if (w_jam_entry && (r_jam_count != 8'hFF)) begin
                r_jam_count <= r_jam_count + 8'd1;
            end
        end
    end

    assign coin_count = r_coin_count;
    assign jam_count  = r_jam_count;
`endif

endmodule
`default_nettype wire
